// File: rtl/glip_channel_pkg.sv
// Shared helpers for the GLIP channel arbiter: index sizing and round-robin search.
package glip_channel_pkg;

    localparam int unsigned MAX_CHANNELS = 32;
    localparam int unsigned MAX_IDX_W    = 5;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First valid index after 'last', wrapping modulo n; returns 'last' if none is valid.
    function automatic int unsigned rr_select(input logic [MAX_CHANNELS-1:0] valid,
                                              input int unsigned last,
                                              input int unsigned n);
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if ((k <= n) && !found && valid[idx[MAX_IDX_W-1:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/glip_channel_if.sv
// N input valid/ready channels merged onto one output valid/ready channel.
interface glip_channel_if #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_CHANNELS = 2
);
    logic [NUM_CHANNELS*WIDTH-1:0] in_data;
    logic [NUM_CHANNELS-1:0]       in_valid;
    logic [NUM_CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]              out_data;
    logic                          out_valid;
    logic                          out_ready;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
endinterface

// File: rtl/glip_channel_skid.sv
// Two-entry FIFO register slice; ready is registered so downstream ready never reaches upstream.
module glip_channel_skid #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    logic             r_head_valid, r_tail_valid, r_ready;
    logic [WIDTH-1:0] r_head_data, r_tail_data;
    logic             w_head_valid, w_tail_valid, w_ready;
    logic [WIDTH-1:0] w_head_data, w_tail_data;
    logic             w_push, w_pop;

    always_comb begin
        w_head_valid = r_head_valid;
        w_tail_valid = r_tail_valid;
        w_head_data  = r_head_data;
        w_tail_data  = r_tail_data;
        w_push       = i_valid && r_ready;
        w_pop        = r_head_valid && i_ready;
        if (w_pop) begin
            w_head_valid = r_tail_valid;
            w_tail_valid = 1'b0;
            if (r_tail_valid) w_head_data = r_tail_data;
        end
        // Push lands in the head if it is free after the pop, else behind it.
        if (w_push) begin
            if (!w_head_valid) begin
                w_head_valid = 1'b1;
                w_head_data  = i_data;
            end else begin
                w_tail_valid = 1'b1;
                w_tail_data  = i_data;
            end
        end
        w_ready = !(w_head_valid && w_tail_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
            r_head_data  <= '0;
            r_tail_data  <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_head_valid <= w_head_valid;
            r_tail_valid <= w_tail_valid;
            r_head_data  <= w_head_data;
            r_tail_data  <= w_tail_data;
            r_ready      <= w_ready;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_head_valid;
    assign o_data  = r_head_data;

endmodule

// File: rtl/glip_channel_arbiter.sv
// Round-robin N:1 channel merge with optional burst lock, feeding a registered skid stage.
module glip_channel_arbiter
    import glip_channel_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned MAX_BURST    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    glip_channel_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(NUM_CHANNELS);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [IDX_W-1:0]        r_gnt, w_sel;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_locked, w_locked_nxt;
    logic                    w_any_valid, w_gnt_valid, w_push, w_skid_ready;
    logic [WIDTH-1:0]        w_sel_data;
    logic [MAX_CHANNELS-1:0] w_valid_pad;

    always_comb begin
        w_valid_pad = MAX_CHANNELS'(bus.in_valid);
        w_any_valid = |bus.in_valid;
        w_gnt_valid = w_valid_pad[MAX_IDX_W'(r_gnt)];
        // The lock only holds while the locked channel still has data.
        if (r_locked && w_gnt_valid) w_sel = r_gnt;
        else w_sel = IDX_W'(rr_select(w_valid_pad, 32'(r_gnt), NUM_CHANNELS));
        w_push      = w_any_valid && w_skid_ready;
        bus.in_ready = '0;
        w_sel_data   = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_data      = bus.in_data[i*WIDTH +: WIDTH];
                bus.in_ready[i] = w_push;
            end
        end
        if (r_locked && (w_sel == r_gnt))
            w_cnt_nxt = (r_cnt == CNT_W'(MAX_BURST)) ? r_cnt : r_cnt + CNT_W'(1);
        else
            w_cnt_nxt = CNT_W'(1);
        w_locked_nxt = (w_cnt_nxt < CNT_W'(MAX_BURST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= IDX_W'(NUM_CHANNELS - 1);
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (w_push) begin
            r_gnt    <= w_sel;
            r_cnt    <= w_cnt_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    glip_channel_skid #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_any_valid),
        .i_data  (w_sel_data),
        .o_ready (w_skid_ready),
        .o_valid (bus.out_valid),
        .o_data  (bus.out_data),
        .i_ready (bus.out_ready)
    );

endmodule

// File: tb/tb_glip_channel_arbiter.sv
// Bench for glip_channel_arbiter: a burst-locking (MAX_BURST=3) and a per-beat (MAX_BURST=1) instance.
module tb_glip_channel_arbiter;
    localparam int W = 16;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] s_data   [2];
    logic [N-1:0]   s_valid  [2];
    logic           s_oready [2];
    logic [N-1:0]   d_ready  [2];
    logic           d_ov     [2];
    logic [W-1:0]   d_od     [2];

    glip_channel_if #(.WIDTH(W), .NUM_CHANNELS(N)) bus0 ();
    glip_channel_if #(.WIDTH(W), .NUM_CHANNELS(N)) bus1 ();

    assign bus0.in_data   = s_data[0];
    assign bus0.in_valid  = s_valid[0];
    assign bus0.out_ready = s_oready[0];
    assign bus1.in_data   = s_data[1];
    assign bus1.in_valid  = s_valid[1];
    assign bus1.out_ready = s_oready[1];
    assign d_ready[0] = bus0.in_ready;
    assign d_ov[0]    = bus0.out_valid;
    assign d_od[0]    = bus0.out_data;
    assign d_ready[1] = bus1.in_ready;
    assign d_ov[1]    = bus1.out_valid;
    assign d_od[1]    = bus1.out_data;

    glip_channel_arbiter #(.WIDTH(W), .NUM_CHANNELS(N), .MAX_BURST(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    glip_channel_arbiter #(.WIDTH(W), .NUM_CHANNELS(N), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    // Source state and behavioural model state, one slot per DUT
    logic [W-1:0] src_d [2][N];
    bit           src_v [2][N];
    int           mb    [2] = '{3, 1};
    int           m_gnt [2];
    int           m_cnt [2];
    bit           m_lock[2];
    logic [W-1:0] m_buf [2][2];
    int           m_n   [2];
    bit           m_rdy [2];
    int           s_next, s_k, acc;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] rdy_b3;
        logic [N-1:0] rdy_b1;
    } vec_t;
    vec_t tbl [25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) begin
                s_data[d][c*W +: W] = src_d[d][c];
                s_valid[d][c]       = src_v[d][c];
            end
    endtask

    task automatic clear_src();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) begin
                src_v[d][c] = 1'b0;
                src_d[d][c] = '0;
            end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        s_oready[0] = 1'b1;
        s_oready[1] = 1'b1;
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Grant rule: stay on a locked channel that still has data, otherwise next valid after gnt.
    function automatic int model_sel(input int d);
        if (m_lock[d] && src_v[d][m_gnt[d]]) return m_gnt[d];
        for (int k = 1; k <= N; k++)
            if (src_v[d][(m_gnt[d] + k) % N]) return (m_gnt[d] + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input int d);
        int s, nc;
        bit xfer, pop;
        s    = model_sel(d);
        xfer = (s >= 0) && m_rdy[d];
        pop  = (m_n[d] > 0) && s_oready[d];
        if (pop) begin
            m_buf[d][0] = m_buf[d][1];
            m_n[d]--;
        end
        if (xfer) begin
            m_buf[d][m_n[d]] = src_d[d][s];
            m_n[d]++;
            nc = (m_lock[d] && s == m_gnt[d]) ? ((m_cnt[d] + 1 > mb[d]) ? mb[d] : m_cnt[d] + 1) : 1;
            m_gnt[d]  = s;
            m_cnt[d]  = nc;
            m_lock[d] = nc < mb[d];
            src_v[d][s] = 1'b0;
        end
        m_rdy[d] = m_n[d] < 2;
    endtask

    task automatic model_reset_start();
        rst_n = 1'b0;
        clear_src();
        s_oready[0] = 1'b1;
        s_oready[1] = 1'b1;
        drive();
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = N - 1; m_cnt[d] = 0; m_lock[d] = 1'b0; m_n[d] = 0; m_rdy[d] = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic step(input bit stream_mode);
        int s;
        logic [N-1:0] er;
        for (int d = 0; d < 2; d++) begin
            s  = model_sel(d);
            er = '0;
            if (s >= 0 && m_rdy[d]) er[s] = 1'b1;
            chk("rnd_in_ready", 64'(d_ready[d]), 64'(er));
            chk("rnd_out_valid", 64'(d_ov[d]), 64'(m_n[d] > 0));
            if (m_n[d] > 0) chk("rnd_out_data", 64'(d_od[d]), 64'(m_buf[d][0]));
        end
        if (stream_mode && d_ov[0] && s_oready[0]) begin
            chk("stream_data", 64'(d_od[0]), 64'(16'h00A0 + W'(s_k)));
            s_k++;
        end
        if (s_oready[0]) acc = 0;
        else if ((d_ready[0] & s_valid[0]) != '0) begin
            acc++;
            chk("stall_accept_le2", 64'(acc <= 2), 64'd1);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            model_edge(d);
            for (int c = 0; c < N; c++) begin
                if (!src_v[d][c]) begin
                    if (stream_mode) begin
                        if (d == 0 && c == 0 && s_next < 10) begin
                            src_v[d][c] = 1'b1;
                            src_d[d][c] = 16'h00A0 + W'(s_next);
                            s_next++;
                        end
                    end else if ($urandom_range(0, 2) != 0) begin
                        src_v[d][c] = 1'b1;
                        src_d[d][c] = W'($urandom);
                    end
                end
            end
            s_oready[d] = stream_mode ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
        end
        drive();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b011, 3'b001, 3'b001};
        tbl[1]  = '{3'b011, 3'b001, 3'b010};
        tbl[2]  = '{3'b011, 3'b001, 3'b001};
        tbl[3]  = '{3'b011, 3'b010, 3'b010};
        tbl[4]  = '{3'b011, 3'b010, 3'b001};
        tbl[5]  = '{3'b011, 3'b010, 3'b010};
        tbl[6]  = '{3'b011, 3'b001, 3'b001};
        tbl[7]  = '{3'b011, 3'b001, 3'b010};
        tbl[8]  = '{3'b010, 3'b010, 3'b010};
        tbl[9]  = '{3'b011, 3'b010, 3'b001};
        tbl[10] = '{3'b011, 3'b010, 3'b010};
        tbl[11] = '{3'b011, 3'b001, 3'b001};
        tbl[12] = '{3'b011, 3'b001, 3'b010};
        tbl[13] = '{3'b011, 3'b001, 3'b001};
        tbl[14] = '{3'b011, 3'b010, 3'b010};
        tbl[15] = '{3'b111, 3'b010, 3'b100};
        tbl[16] = '{3'b111, 3'b010, 3'b001};
        tbl[17] = '{3'b111, 3'b100, 3'b010};
        tbl[18] = '{3'b111, 3'b100, 3'b100};
        tbl[19] = '{3'b111, 3'b100, 3'b001};
        tbl[20] = '{3'b111, 3'b001, 3'b010};
        tbl[21] = '{3'b100, 3'b100, 3'b100};
        tbl[22] = '{3'b010, 3'b010, 3'b010};
        tbl[23] = '{3'b001, 3'b001, 3'b001};
        tbl[24] = '{3'b000, 3'b000, 3'b000};

        // Reset values and first-transfer latency
        clear_src();
        s_oready[0] = 1'b1;
        s_oready[1] = 1'b1;
        drive();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(d_ready[d]), 64'd0);
            chk("rst_out_valid", 64'(d_ov[d]), 64'd0);
            chk("rst_out_data", 64'(d_od[d]), 64'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            src_v[d][0] = 1'b1;
            src_d[d][0] = 16'h1234;
        end
        drive(); #1;
        chk("ready_before_edge1", 64'(d_ready[0]), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_edge1", 64'(d_ready[0]), 64'b001);
        @(posedge clk); #1;
        clear_src(); drive();
        chk("first_out_valid", 64'(d_ov[0]), 64'd1);
        chk("first_out_data", 64'(d_od[0]), 64'h1234);

        // Arbitration order table: fairness, burst lock, lock break, sparse wrap, idle
        do_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) src_d[d][c] = 16'hC000 + W'(d * 256 + c);
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] exp_r [2];
            exp_r[0] = tbl[r].rdy_b3;
            exp_r[1] = tbl[r].rdy_b1;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < N; c++) src_v[d][c] = tbl[r].valid[c];
            drive(); #1;
            for (int d = 0; d < 2; d++) chk("tbl_in_ready", 64'(d_ready[d]), 64'(exp_r[d]));
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk("tbl_out_valid", 64'(d_ov[d]), 64'(exp_r[d] != '0));
                if (exp_r[d] != '0)
                    chk("tbl_out_data", 64'(d_od[d]), 64'(16'hC000 + W'(d * 256 + onehot_idx(exp_r[d]))));
            end
        end

        // Backpressured stream 0xA0..0xA9 on channel 0
        model_reset_start();
        s_next = 0; s_k = 0; acc = 0;
        for (int cyc = 0; cyc < 300 && s_k < 10; cyc++) step(1'b1);
        chk("stream_count", 64'(s_k), 64'd10);

        // Random traffic on all channels of both instances
        model_reset_start();
        acc = 0;
        repeat (400) step(1'b0);

        // Reset asserted mid-burst with the buffer full
        do_reset();
        s_oready[0] = 1'b0;
        s_oready[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            src_v[d][1] = 1'b1;
            src_d[d][1] = 16'h0111;
        end
        drive();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) src_d[d][1] = 16'h0222;
        drive();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("full_out_valid", 64'(d_ov[d]), 64'd1);
            chk("full_out_data", 64'(d_od[d]), 64'h0111);
            chk("full_in_ready", 64'(d_ready[d]), 64'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_out_valid", 64'(d_ov[d]), 64'd0);
            chk("midrst_out_data", 64'(d_od[d]), 64'd0);
            chk("midrst_in_ready", 64'(d_ready[d]), 64'd0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            src_v[d][0] = 1'b1;
            src_d[d][0] = 16'h0333;
        end
        s_oready[0] = 1'b1;
        s_oready[1] = 1'b1;
        drive();
        rst_n = 1'b1;
        #1;
        chk("postrst_ready_edge0", 64'(d_ready[0]), 64'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("postrst_priority_ch0", 64'(d_ready[d]), 64'b001);
        @(posedge clk); #1;
        chk("postrst_out_data", 64'(d_od[0]), 64'h0333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
